// File: rtl/dw_lzd_norm_pkg.sv
// ---------------------------------------------------------------------------
// dw_lzd_norm_pkg
// Shared elaboration-time helpers for the leading-zero normalization pipe.
//   clog2          : ceil(log2(value)), 0 for value <= 1
//   enc_width_for  : lz-count width needed for a mantissa of a_width bits.
//                    The count spans 0..a_width inclusive, hence the +1.
//   max_width      : larger of two widths, used to size the lz/exp compare
// Default widths for the standard single-stage configuration are also
// provided so that instantiating blocks can refer to one source of truth.
// ---------------------------------------------------------------------------
package dw_lzd_norm_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int enc_width_for(input int a_width);
        return clog2(a_width) + 1;
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_A_WIDTH   = 8;
    localparam int DEF_EXP_WIDTH = 6;
    localparam int DEF_ENC_WIDTH = enc_width_for(DEF_A_WIDTH);

endpackage

// File: rtl/dw_lzd_norm_shl.sv
// ---------------------------------------------------------------------------
// dw_lzd_norm_shl
// Purely combinational logarithmic left shifter with zero fill.
//   data   : A_WIDTH     operand
//   shift  : ENC_WIDTH   shift amount, 0..2**ENC_WIDTH-1
//   result : A_WIDTH     data << shift; any amount >= A_WIDTH yields zero
// Each shift bit k controls one stage shifting by 2**k, giving ENC_WIDTH
// mux levels instead of one wide A_WIDTH:1 mux per output bit.
// ---------------------------------------------------------------------------
module dw_lzd_norm_shl #(
    parameter int A_WIDTH   = 8,
    parameter int ENC_WIDTH = 4
) (
    input  logic [A_WIDTH-1:0]   data,
    input  logic [ENC_WIDTH-1:0] shift,
    output logic [A_WIDTH-1:0]   result
);

    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        result = data;
        for (int k = 0; k < ENC_WIDTH; k++) begin
            if (shift[k]) begin
                // A stage distance at or beyond the operand width flushes
                // everything out; guard it so the shift amount stays legal.
                if ((1 << k) >= A_WIDTH) begin
                    result = '0;
                end else begin
                    result = result << (1 << k);
                end
            end
        end
    end

endmodule

// File: rtl/dw_lzd_normalize_pipe.sv
// ---------------------------------------------------------------------------
// dw_lzd_normalize_pipe
// Two-stage valid/ready normalization pipe placed after the leading-zero
// detector. Stage 1 registers the operand together with its leading-zero
// count; stage 2 shifts the mantissa left by min(lz, exp), lowers the
// exponent by the same amount and flags denormal / zero results.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   pipe can take an operand this cycle (combinational from
//              out_ready so a full pipe still streams one per cycle)
//   in_mant    unnormalized mantissa           [A_WIDTH]
//   in_exp     unsigned exponent               [EXP_WIDTH]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_mant   normalized mantissa             [A_WIDTH]
//   out_exp    adjusted exponent               [EXP_WIDTH]
//   out_lz     raw leading-zero count of in_mant, A_WIDTH for zero [ENC_WIDTH]
//   out_den    shift was clamped by the exponent (lz > exp, non-zero mant)
//   out_zero   in_mant was all zeros
// ---------------------------------------------------------------------------
module dw_lzd_normalize_pipe
    import dw_lzd_norm_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int ENC_WIDTH = DEF_ENC_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_mant,
    input  logic [EXP_WIDTH-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_WIDTH-1:0]   out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic [ENC_WIDTH-1:0] out_lz,
    output logic                 out_den,
    output logic                 out_zero
);

    // lz and exp are compared at a common width so neither side wraps.
    localparam int CMP_WIDTH = max_width(ENC_WIDTH, EXP_WIDTH);

    generate
        if (ENC_WIDTH != enc_width_for(A_WIDTH)) begin : g_bad_enc_width
            $error("dw_lzd_normalize_pipe: ENC_WIDTH must equal ceil(log2(A_WIDTH))+1");
        end
        if (A_WIDTH < 2) begin : g_bad_a_width
            $error("dw_lzd_normalize_pipe: A_WIDTH must be at least 2");
        end
    endgenerate

    typedef struct packed {
        logic [A_WIDTH-1:0]   mant;
        logic [EXP_WIDTH-1:0] expn;
        logic [ENC_WIDTH-1:0] lz;
    } stage1_t;

    typedef struct packed {
        logic [A_WIDTH-1:0]   mant;
        logic [EXP_WIDTH-1:0] expn;
        logic [ENC_WIDTH-1:0] lz;
        logic                 den;
        logic                 zero;
    } result_t;

    // -----------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its contents leave
    // this cycle. The ready chain is combinational end to end.
    // -----------------------------------------------------------------------
    logic v1;
    logic v2;
    logic adv1;
    logic adv2;

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // -----------------------------------------------------------------------
    // Leading-zero count of the incoming mantissa. Scanning upward lets the
    // highest set bit win; an all-zero word keeps the default of A_WIDTH.
    // -----------------------------------------------------------------------
    logic [ENC_WIDTH-1:0] lz_in;

    always_comb begin
        lz_in = ENC_WIDTH'(A_WIDTH);
        for (int i = 0; i < A_WIDTH; i++) begin
            if (in_mant[i]) begin
                lz_in = ENC_WIDTH'(A_WIDTH - 1 - i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1 register
    // -----------------------------------------------------------------------
    stage1_t s1;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            v1 <= 1'b0;
            // NOTE: the data registers are reset as well so the visible
            // outputs read zero rather than X straight after reset.
            s1 <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
            end
            // Loading only on a real accept keeps idle cycles from toggling
            // the wide data registers.
            if (adv1 && in_valid) begin
                s1 <= '{mant: in_mant, expn: in_exp, lz: lz_in};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 datapath: clamp the shift by the exponent, shift, adjust.
    // -----------------------------------------------------------------------
    logic [CMP_WIDTH-1:0] lz_cmp;
    logic [CMP_WIDTH-1:0] exp_cmp;
    logic [CMP_WIDTH-1:0] sh_cmp;
    logic [ENC_WIDTH-1:0] sh;
    logic                 clamp;
    logic                 s1_zero;
    logic [A_WIDTH-1:0]   shifted;
    result_t              res_next;

    assign lz_cmp  = CMP_WIDTH'(s1.lz);
    assign exp_cmp = CMP_WIDTH'(s1.expn);
    assign clamp   = lz_cmp > exp_cmp;
    assign s1_zero = (s1.mant == '0);
    // When clamped, exp < lz <= A_WIDTH, so the amount always fits ENC_WIDTH.
    assign sh_cmp  = clamp ? exp_cmp : lz_cmp;
    assign sh      = ENC_WIDTH'(sh_cmp);

    dw_lzd_norm_shl #(
        .A_WIDTH   (A_WIDTH),
        .ENC_WIDTH (ENC_WIDTH)
    ) u_shl (
        .data   (s1.mant),
        .shift  (sh),
        .result (shifted)
    );

    always_comb begin
        res_next.mant = shifted;
        res_next.expn = EXP_WIDTH'(exp_cmp - sh_cmp);
        res_next.lz   = s1.lz;
        res_next.den  = clamp && !s1_zero;
        res_next.zero = s1_zero;
        // A zero mantissa has no leading one to align; report exponent 0.
        if (s1_zero) begin
            res_next.mant = '0;
            res_next.expn = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 register; holds its contents while stalled downstream.
    // -----------------------------------------------------------------------
    result_t res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            res <= '0;
        end else begin
            if (adv2) begin
                v2 <= v1;
            end
            if (adv2 && v1) begin
                res <= res_next;
            end
        end
    end

    assign out_valid = v2;
    assign out_mant  = res.mant;
    assign out_exp   = res.expn;
    assign out_lz    = res.lz;
    assign out_den   = res.den;
    assign out_zero  = res.zero;

endmodule

// File: tb/tb_dw_lzd_normalize_pipe.sv
// ---------------------------------------------------------------------------
// tb_dw_lzd_normalize_pipe
// Self-checking bench for dw_lzd_normalize_pipe (A_WIDTH=8, EXP_WIDTH=6).
// A negedge monitor predicts every accepted operand with an arithmetic
// reference model and compares results in order as they leave the pipe.
// Directed cases, a back-pressure scenario, a mid-stream reset and a long
// randomly throttled run are layered on top.
// ---------------------------------------------------------------------------
module tb_dw_lzd_normalize_pipe;

    localparam int A_WIDTH   = 8;
    localparam int ENC_WIDTH = 4;
    localparam int EXP_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [A_WIDTH-1:0]   in_mant = '0;
    logic [EXP_WIDTH-1:0] in_exp = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [A_WIDTH-1:0]   out_mant;
    logic [EXP_WIDTH-1:0] out_exp;
    logic [ENC_WIDTH-1:0] out_lz;
    logic                 out_den;
    logic                 out_zero;

    // Packed view of a result: {mant[7:0], exp[5:0], lz[3:0], den, zero}.
    logic [19:0] out_pack;
    assign out_pack = {out_mant, out_exp, out_lz, out_den, out_zero};

    int checks = 0;
    int errors = 0;
    int in_count = 0;
    int out_count = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    dw_lzd_normalize_pipe #(
        .A_WIDTH   (A_WIDTH),
        .ENC_WIDTH (ENC_WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_lz    (out_lz),
        .out_den   (out_den),
        .out_zero  (out_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: count significant bits arithmetically, then clamp/shift.
    function automatic logic [19:0] model(input logic [7:0] m, input logic [5:0] e);
        int v;
        int bits;
        int lz;
        int sh;
        int mo;
        int eo;
        bit zero;
        bit den;
        v = int'(m);
        bits = 0;
        while (v > 0) begin
            v = v / 2;
            bits++;
        end
        lz   = A_WIDTH - bits;
        zero = (m == 0);
        sh   = (lz < int'(e)) ? lz : int'(e);
        mo   = (int'(m) * (1 << sh)) % 256;
        eo   = int'(e) - sh;
        den  = !zero && (lz > int'(e));
        if (zero) begin
            mo = 0;
            eo = 0;
        end
        return {mo[7:0], eo[5:0], lz[3:0], den, zero};
    endfunction

    // Scoreboard: sampled on the falling edge, i.e. just before the rising
    // edge where the accept / transfer actually takes place.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_mant, in_exp));
                in_count++;
            end
            if (out_valid && out_ready) begin
                out_count++;
                check("sb_no_spurious", 32'(out_count <= in_count), 32'd1);
                if (exp_q.size() > 0) begin
                    check("sb_result", 32'(out_pack), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // One operand with out_ready high; result must appear exactly 2 edges on.
    task automatic directed(input string tag, input logic [7:0] m, input logic [5:0] e,
                            input logic [19:0] want);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mant   = m;
        in_exp    = e;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_pack), 32'(want));
    endtask

    initial begin
        logic [7:0]  sm[6];
        logic [5:0]  se[6];
        logic [20:0] snap;
        int          idx;
        int          base_in;
        int          base_out;
        int          cyc;
        bit          fire;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_pack), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- directed cases ----------------
        directed("d_0x10_e10", 8'h10, 6'd10, {8'h80, 6'd7,  4'd3, 1'b0, 1'b0});
        directed("d_0x01_e3",  8'h01, 6'd3,  {8'h08, 6'd0,  4'd7, 1'b1, 1'b0});
        directed("d_zero_e20", 8'h00, 6'd20, {8'h00, 6'd0,  4'd8, 1'b0, 1'b1});
        directed("d_0x80_e0",  8'h80, 6'd0,  {8'h80, 6'd0,  4'd0, 1'b0, 1'b0});
        directed("d_0x40_e63", 8'h40, 6'd63, {8'h80, 6'd62, 4'd1, 1'b0, 1'b0});
        directed("d_lz_eq_e",  8'h01, 6'd7,  {8'h80, 6'd0,  4'd7, 1'b0, 1'b0});
        directed("d_zero_e0",  8'h00, 6'd0,  {8'h00, 6'd0,  4'd8, 1'b0, 1'b1});
        @(posedge clk); #1;

        // ---------------- back-pressure: 6 ops, 5 stalled cycles ----------------
        for (int i = 0; i < 6; i++) begin
            sm[i] = 8'($urandom_range(1, 255));
            se[i] = 6'($urandom_range(0, 63));
        end
        out_ready = 1'b0;
        idx  = 0;
        snap = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_mant  = sm[idx];
            in_exp   = se[idx];
            @(negedge clk);
            fire = in_valid && in_ready;
            if (c == 2) snap = {out_valid, out_pack};
            @(posedge clk); #1;
            if (fire) idx++;
        end
        check("stall_accepts", 32'(idx), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({out_valid, out_pack}), 32'(snap));

        out_ready = 1'b1;
        base_out  = out_count;
        for (int c = 0; c < 6; c++) begin
            if (idx < 6) begin
                in_valid = 1'b1;
                in_mant  = sm[idx];
                in_exp   = se[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        check("release_all_in", 32'(idx), 32'd6);
        check("release_6_in_6cyc", 32'(out_count - base_out), 32'd6);

        // ---------------- reset with two operands in flight ----------------
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_mant  = 8'($urandom_range(1, 255));
            in_exp   = 6'($urandom_range(0, 63));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_pack), 32'd0);
        exp_q.delete();
        in_count = out_count;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        base_out  = out_count;
        in_valid  = 1'b1;
        in_mant   = 8'h23;
        in_exp    = 6'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_single_out", 32'(out_count - base_out), 32'd1);

        // ---------------- randomized throttled run ----------------
        base_in = in_count;
        cyc     = 0;
        while ((in_count - base_in) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mant   = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
            in_exp    = 6'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("rnd_accepts", 32'(in_count - base_in), 32'd10000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
